// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type, width helpers and fixed-point constants for conv_complex_stream
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_MAC    = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  function automatic int word_length(input int qi, input int qf);
    return qi + qf;
  endfunction

  function automatic int prod_w(input int qi, input int qf);
    return 2 * word_length(qi, qf) + 1;
  endfunction

  function automatic int acc_w(input int qi, input int qf, input int k);
    return prod_w(qi, qf) + $clog2(k);
  endfunction

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  function automatic int round_bias(input int qf);
    return 1 << (qf - 1);
  endfunction

  // {Re,Im} packing: Re occupies the upper w bits, both two's complement
  function automatic logic [63:0] pack_ri(input int re, input int im, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return ((64'(re) & mask) << w) | (64'(im) & mask);
  endfunction

  function automatic int unpack_re(input logic [63:0] d, input int w);
    logic [63:0] t;
    t = (d >> w) << (64 - w);
    return int'($signed(t) >>> (64 - w));
  endfunction

  function automatic int unpack_im(input logic [63:0] d, input int w);
    logic [63:0] t;
    t = d << (64 - w);
    return int'($signed(t) >>> (64 - w));
  endfunction

endpackage

// File: rtl/cmult_full_fixed.sv
// rtl/cmult_full_fixed.sv - combinational full-precision complex multiply, 2*QF fractional bits out
module cmult_full_fixed
  import conv_pkg::*;
#(
  parameter int QI = 3,
  parameter int QF = 3,
  localparam int W   = word_length(QI, QF),
  localparam int P_W = prod_w(QI, QF)
) (
  input  logic [2*W-1:0]        a,
  input  logic [2*W-1:0]        b,
  output logic signed [P_W-1:0] p_re,
  output logic signed [P_W-1:0] p_im
);

  int ar, ai, br, bi;

  always_comb begin
    ar   = unpack_re(64'(a), W);
    ai   = unpack_im(64'(a), W);
    br   = unpack_re(64'(b), W);
    bi   = unpack_im(64'(b), W);
    p_re = P_W'(ar * br - ai * bi);
    p_im = P_W'(ar * bi + ai * br);
  end

endmodule

// File: rtl/conv_complex_stream.sv
// rtl/conv_complex_stream.sv - streaming complex full convolution with one time-multiplexed MAC
module conv_complex_stream
  import conv_pkg::*;
#(
  parameter int QI          = 3,
  parameter int QF          = 3,
  parameter int KERNEL_LEN  = 3,
  parameter int MAX_SAMPLES = 100,
  localparam int W     = word_length(QI, QF),
  localparam int KA_W  = $clog2(KERNEL_LEN),
  localparam int CNT_W = $clog2(MAX_SAMPLES + KERNEL_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             k_wr_en,
  input  logic [KA_W-1:0]  k_wr_addr,
  input  logic [2*W-1:0]   k_wr_data,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             s_valid,
  input  logic [2*W-1:0]   s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [2*W-1:0]   m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int P_W   = prod_w(QI, QF);
  localparam int ACC_W = acc_w(QI, QF, KERNEL_LEN);
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(round_bias(QF));
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(W));

  state_t                  state, state_n;
  logic [2*W-1:0]          tap [KERNEL_LEN];
  logic [2*W-1:0]          dl  [KERNEL_LEN];
  logic [CNT_W-1:0]        n_reg, in_cnt, out_cnt;
  logic [KA_W-1:0]         mac_k;
  logic signed [ACC_W-1:0] acc_re, acc_im, acc_re_n, acc_im_n;
  logic signed [P_W-1:0]   p_re, p_im;
  logic [W:0]              rs_re, rs_im;
  logic                    in_room, mac_last, out_last;

  // Returns {saturated, value}: round half-up, drop QF bits, clamp to W bits
  function automatic logic [W:0] rnd_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    r = (v + RND) >>> QF;
    if (r > SAT_HI)      return {1'b1, SAT_HI[W-1:0]};
    else if (r < SAT_LO) return {1'b1, SAT_LO[W-1:0]};
    else                 return {1'b0, r[W-1:0]};
  endfunction

  cmult_full_fixed #(.QI(QI), .QF(QF)) u_cmult (
    .a    (tap[mac_k]),
    .b    (dl[mac_k]),
    .p_re (p_re),
    .p_im (p_im)
  );

  assign in_room  = in_cnt < n_reg;
  assign mac_last = mac_k == KA_W'(KERNEL_LEN - 1);
  assign out_last = out_cnt == n_reg + CNT_W'(KERNEL_LEN - 2);
  assign acc_re_n = acc_re + ACC_W'(p_re);
  assign acc_im_n = acc_im + ACC_W'(p_im);
  assign rs_re    = rnd_sat(acc_re_n);
  assign rs_im    = rnd_sat(acc_im_n);
  assign busy     = state != ST_IDLE;
  assign m_last   = (state == ST_EMIT) && out_last;

  always_comb begin
    state_n = state;
    s_ready = 1'b0;
    m_valid = 1'b0;
    case (state)
      ST_IDLE:
        if (start && num_samples != '0) state_n = ST_ACCEPT;
      ST_ACCEPT: begin
        s_ready = in_room;
        // Once all samples are in, zeros are shifted in to flush the tail
        if (!in_room || s_valid) state_n = ST_MAC;
      end
      ST_MAC:
        if (mac_last) state_n = ST_EMIT;
      ST_EMIT: begin
        m_valid = 1'b1;
        if (m_ready) state_n = out_last ? ST_IDLE : ST_ACCEPT;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      for (int i = 0; i < KERNEL_LEN; i++) begin
        tap[i] <= '0;
        dl[i]  <= '0;
      end
      n_reg    <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      mac_k    <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      m_data   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (k_wr_en && int'(k_wr_addr) < KERNEL_LEN) tap[k_wr_addr] <= k_wr_data;
          if (start) begin
            n_reg    <= num_samples;
            in_cnt   <= '0;
            out_cnt  <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < KERNEL_LEN; i++) dl[i] <= '0;
            done     <= (num_samples == '0);
          end
        end
        ST_ACCEPT: begin
          acc_re <= '0;
          acc_im <= '0;
          mac_k  <= '0;
          if (!in_room || s_valid) begin
            dl[0] <= in_room ? s_data : '0;
            for (int i = 1; i < KERNEL_LEN; i++) dl[i] <= dl[i-1];
          end
          if (in_room && s_valid) in_cnt <= in_cnt + CNT_W'(1);
        end
        ST_MAC: begin
          acc_re <= acc_re_n;
          acc_im <= acc_im_n;
          mac_k  <= mac_k + KA_W'(1);
          if (mac_last) begin
            m_data <= (2*W)'(pack_ri(int'($signed(rs_re[W-1:0])), int'($signed(rs_im[W-1:0])), W));
            if (rs_re[W] || rs_im[W]) overflow <= 1'b1;
          end
        end
        ST_EMIT:
          if (m_ready) begin
            out_cnt <= out_cnt + CNT_W'(1);
            if (out_last) done <= 1'b1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_complex_stream.sv
// tb/tb_conv_complex_stream.sv - randomized self-checking bench for conv_complex_stream
module tb_conv_complex_stream;

  localparam int K     = 3;
  localparam int W     = 6;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             k_wr_en;
  logic [1:0]       k_wr_addr;
  logic [2*W-1:0]   k_wr_data;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             s_valid;
  logic [2*W-1:0]   s_data;
  logic             s_ready;
  logic             m_valid;
  logic [2*W-1:0]   m_data;
  logic             m_last;
  logic             m_ready;
  logic             busy;
  logic             done;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  int hr[K], hi[K];
  int xr[$], xi[$];
  int exp_re[$], exp_im[$];

  conv_complex_stream dut (
    .clk(clk), .rst(rst), .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
    .start(start), .num_samples(num_samples), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pk(input int re, input int im);
    return {6'(re), 6'(im)};
  endfunction

  function automatic int rnd6();
    return int'($urandom_range(0, 63)) - 32;
  endfunction

  // Output j = sum h[k]*x[j-k]; scale 1.0 = 8, round half-up, clamp to [-32,31]
  function automatic bit build_model(input int n);
    bit ov = 0;
    exp_re.delete();
    exp_im.delete();
    for (int j = 0; j < n + K - 1; j++) begin
      int sr = 0, si = 0, qr, qi;
      for (int k = 0; k < K; k++) begin
        int i = j - k;
        if (i >= 0 && i < n) begin
          sr += hr[k] * xr[i] - hi[k] * xi[i];
          si += hr[k] * xi[i] + hi[k] * xr[i];
        end
      end
      qr = (sr + 4) >>> 3;
      qi = (si + 4) >>> 3;
      if (qr > 31) begin qr = 31; ov = 1; end
      if (qr < -32) begin qr = -32; ov = 1; end
      if (qi > 31) begin qi = 31; ov = 1; end
      if (qi < -32) begin qi = -32; ov = 1; end
      exp_re.push_back(qr);
      exp_im.push_back(qi);
    end
    return ov;
  endfunction

  task automatic load_kernel(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      k_wr_en = 1'b1; k_wr_addr = 2'(k); k_wr_data = pk(hr[k], hi[k]);
    end
    @(negedge clk);
    k_wr_en = 1'b0;
  endtask

  // mode 0: always ready; 1: random valid/ready plus ignored start/k_wr_en; 2: 10-cycle stall on output 1
  task automatic do_run(input string name, input int n, input int mode, input bit co_write);
    bit exp_ovf;
    int nout, in_idx, out_idx, cyc, acc_cyc, hold, dones;
    bit lat_seen;
    logic [11:0] held_data;
    logic held_last;
    exp_ovf = build_model(n);
    @(negedge clk);
    start = 1'b1; num_samples = CNT_W'(n); m_ready = 1'b1; s_valid = 1'b0;
    if (co_write) begin k_wr_en = 1'b1; k_wr_addr = 2'(K - 1); k_wr_data = pk(hr[K-1], hi[K-1]); end
    @(negedge clk);
    start = 1'b0; k_wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL %s ovf_clear got %b want 0", name, overflow); end
    if (n == 0) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
        errors++; $display("FAIL %s n0_done got done=%b busy=%b m_valid=%b want 1 0 0", name, done, busy, m_valid);
      end
      dones = 0;
      repeat (4) begin @(negedge clk); if (done || m_valid) dones++; end
      checks++;
      if (dones !== 0) begin errors++; $display("FAIL %s n0_quiet got %0d events want 0", name, dones); end
      return;
    end
    nout = n + K - 1; in_idx = 0; out_idx = 0; cyc = 0; acc_cyc = -1; hold = 0; dones = 0; lat_seen = 0;
    while (out_idx < nout && cyc < 2000) begin
      if (done) dones++;
      s_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : (in_idx < n);
      s_data  = (in_idx < n) ? pk(xr[in_idx], xi[in_idx]) : pk(rnd6(), rnd6());
      if (mode == 2 && out_idx == 1 && m_valid && hold < 10) begin
        if (hold == 0) begin
          held_data = m_data; held_last = m_last;
        end else begin
          checks++;
          if (m_data !== held_data || m_last !== held_last || s_ready !== 1'b0 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s stall got data=%h last=%b s_ready=%b want data=%h last=%b s_ready=0",
                     name, m_data, m_last, s_ready, held_data, held_last);
          end
        end
        hold++;
        m_ready = 1'b0;
      end else begin
        m_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (mode == 1 && busy) begin
        start = ($urandom_range(0, 5) == 0); k_wr_en = ($urandom_range(0, 5) == 0);
        k_wr_addr = 2'($urandom_range(0, 3)); k_wr_data = pk(rnd6(), rnd6());
        num_samples = CNT_W'($urandom_range(0, 20));
      end else begin
        start = 1'b0; k_wr_en = 1'b0;
      end
      if (s_valid && s_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        in_idx++;
      end
      if (m_valid && !lat_seen) begin
        lat_seen = 1;
        checks++;
        if (cyc - acc_cyc !== K + 1) begin
          errors++; $display("FAIL %s latency got %0d want %0d", name, cyc - acc_cyc, K + 1);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== pk(exp_re[out_idx], exp_im[out_idx]) || m_last !== (out_idx == nout - 1)) begin
          errors++;
          $display("FAIL %s out%0d got data=%h last=%b want data=%h last=%b", name, out_idx,
                   m_data, m_last, pk(exp_re[out_idx], exp_im[out_idx]), out_idx == nout - 1);
        end
        out_idx++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b1; start = 1'b0; k_wr_en = 1'b0;
    checks++;
    if (out_idx != nout || in_idx != n) begin
      errors++; $display("FAIL %s count got out=%0d in=%0d want out=%0d in=%0d", name, out_idx, in_idx, nout, n);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || dones !== 0) begin
      errors++; $display("FAIL %s done got done=%b busy=%b m_valid=%b early=%0d want 1 0 0 0", name, done, busy, m_valid, dones);
    end
    checks++;
    if (overflow !== exp_ovf) begin errors++; $display("FAIL %s overflow got %b want %b", name, overflow, exp_ovf); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse got %b want 0", name, done); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({m_valid, s_ready, busy, done, overflow, m_last} !== 6'b0 || m_data !== '0) begin
      errors++; $display("FAIL reset got flags=%b data=%h want 0", {m_valid, s_ready, busy, done, overflow, m_last}, m_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL idle got busy=%b s_ready=%b want 0", busy, s_ready); end
  endtask

  task automatic test_impulse();
    hr = '{8, 0, 0}; hi = '{0, 0, 0};
    load_kernel(K);
    xr = '{8, 16, 0}; xi = '{8, -8, 4};
    do_run("impulse", 3, 0, 0);
  endtask

  task automatic test_box();
    hr = '{8, 8, 8}; hi = '{0, 0, 0};
    load_kernel(K - 1);
    xr = '{8, 8, 8}; xi = '{0, 0, 0};
    do_run("box", 3, 0, 1);
  endtask

  task automatic test_complex();
    hr = '{0, 0, 0}; hi = '{8, 0, 0};
    load_kernel(K);
    xr = '{0}; xi = '{8};
    do_run("complex", 1, 0, 0);
  endtask

  task automatic test_saturation();
    hr = '{31, 31, 0}; hi = '{0, 0, 0};
    load_kernel(K);
    xr = '{31, 31}; xi = '{0, 0};
    do_run("saturate", 2, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL sticky_ovf got %b want 1", overflow); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < K; k++) begin hr[k] = rnd6(); hi[k] = rnd6(); end
    load_kernel(K);
    xr.delete(); xi.delete();
    for (int i = 0; i < 6; i++) begin xr.push_back(rnd6()); xi.push_back(rnd6()); end
    do_run("backpressure", 6, 2, 0);
    do_run("n_zero", 0, 0, 0);
  endtask

  task automatic test_reset_mid_mac();
    int evts = 0;
    hr = '{8, 8, 8}; hi = '{0, 0, 0};
    load_kernel(K);
    @(negedge clk);
    start = 1'b1; num_samples = CNT_W'(3);
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = pk(8, 0);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL in_mac got busy=%b s_ready=%b m_valid=%b want 1 0 0", busy, s_ready, m_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({m_valid, s_ready, busy, done, overflow, m_last} !== 6'b0 || m_data !== '0) begin
      errors++; $display("FAIL mid_reset got flags=%b data=%h want 0", {m_valid, s_ready, busy, done, overflow, m_last}, m_data);
    end
    repeat (8) begin @(negedge clk); if (done || busy) evts++; end
    checks++;
    if (evts !== 0) begin errors++; $display("FAIL mid_reset_quiet got %0d events want 0", evts); end
    hr = '{0, 0, 0};
    xr = '{8, 8, 8}; xi = '{0, 0, 0};
    do_run("taps_cleared", 3, 0, 0);
    hr = '{8, 8, 8};
    load_kernel(K);
    do_run("box_after_reset", 3, 0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int k = 0; k < K; k++) begin hr[k] = rnd6(); hi[k] = rnd6(); end
      load_kernel(K - 1);
      xr.delete(); xi.delete();
      for (int i = 0; i < n; i++) begin xr.push_back(rnd6()); xi.push_back(rnd6()); end
      do_run("random", n, 1, 1);
    end
  endtask

  initial begin
    rst = 1'b1; k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0; start = 1'b0;
    num_samples = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    test_reset();
    test_impulse();
    test_box();
    test_complex();
    test_saturation();
    test_backpressure();
    test_reset_mid_mac();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
